ram_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the 128 x 8 single-port synchronous RAM (`ram_simple`). It accepts read/write commands from two independent masters over a req/ack handshake, serialises them with round-robin fairness, drives the RAM's `we`/`addr`/`data_in` pins, and returns read data to the winning requester. It sits directly in front of the RAM; the RAM has no other master.

---
 rtl/ram_arbiter.sv | 133 +++++++++++++
 tb/tb_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter and access sequencer for a
// 128 x 8 single-port synchronous RAM with a registered read port.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic              cmd_we, cmd_we_nx;
    logic              cmd_port, cmd_port_nx;
    logic              prio, prio_nx;
    logic              grant1;
    logic              ack0_nx, ack1_nx, busy_nx, ram_we_nx;
    logic [DATA_W-1:0] rdata0_nx, rdata1_nx, ram_din_nx;
    logic [ADDR_W-1:0] ram_addr_nx;

    // Port 1 wins when it is the sole requester or holds priority in a tie.
    always_comb grant1 = req1 & (~req0 | prio);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state, command latch and next output values.
    always_comb begin
        state_nx    = state;
        cmd_we_nx   = cmd_we;
        cmd_port_nx = cmd_port;
        prio_nx     = prio;
        ack0_nx     = 1'b0;
        ack1_nx     = 1'b0;
        rdata0_nx   = rdata0;
        rdata1_nx   = rdata1;
        ram_we_nx   = 1'b0;
        ram_addr_nx = ram_addr;
        ram_din_nx  = ram_din;
        unique case (state)
            S_IDLE: begin
                if (req0 | req1) begin
                    state_nx    = S_ISSUE;
                    cmd_port_nx = grant1;
                    if (grant1) begin
                        cmd_we_nx   = we1;
                        ram_we_nx   = we1;
                        ram_addr_nx = addr1;
                        ram_din_nx  = wdata1;
                    end else begin
                        cmd_we_nx   = we0;
                        ram_we_nx   = we0;
                        ram_addr_nx = addr0;
                        ram_din_nx  = wdata0;
                    end
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                state_nx = S_ACK;
                if (!cmd_we) begin
                    if (cmd_port) rdata1_nx = ram_dout;
                    else          rdata0_nx = ram_dout;
                end
                ack0_nx = ~cmd_port;
                ack1_nx = cmd_port;
            end
            S_ACK: begin
                state_nx = S_IDLE;
                prio_nx  = ~prio;
            end
            default: state_nx = S_IDLE;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    // Registered command, priority and outputs; a write issued in the reset
    // cycle still reaches the RAM because ram_we was registered beforehand.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_we   <= 1'b0;
            cmd_port <= 1'b0;
            prio     <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            busy     <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            cmd_we   <= cmd_we_nx;
            cmd_port <= cmd_port_nx;
            prio     <= prio_nx;
            ack0     <= ack0_nx;
            ack1     <= ack1_nx;
            rdata0   <= rdata0_nx;
            rdata1   <= rdata1_nx;
            busy     <= busy_nx;
            ram_we   <= ram_we_nx;
            ram_addr <= ram_addr_nx;
            ram_din  <= ram_din_nx;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus, transaction-level reference model with
// per-cycle compare, and hand-computed expectations for ram_arbiter.
module tb_ram_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, busy, ram_we;
    logic [DW-1:0] rdata0, rdata1, ram_din;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
        .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM attached to the arbiter's RAM pins.
    logic [DW-1:0] ram_mem [128];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // Transaction model: an access granted at the end of cycle g occupies
    // cycles g+1..g+3, drives the RAM in g+1 and acknowledges in g+3.
    logic [DW-1:0] mem_m [128];
    logic          m_on = 1'b0;
    logic          m_pend, m_prio, m_port, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, m_rd;
    logic [DW-1:0] m_rdata [2];
    int            m_g;

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1; m_pend = 1'b0; m_prio = 1'b0; m_we = 1'b0;
            m_addr = '0; m_din = '0; m_rdata[0] = '0; m_rdata[1] = '0;
        end else if (m_on) begin
            if (m_pend) begin
                if (cyc == m_g + 2 && !m_we) m_rdata[m_port] = m_rd;
                if (cyc == m_g + 3) begin m_pend = 1'b0; m_prio = ~m_prio; end
            end else if (req0 || req1) begin
                m_port = (req0 && req1) ? m_prio : req1;
                m_we   = m_port ? we1 : we0;
                m_addr = m_port ? addr1 : addr0;
                m_din  = m_port ? wdata1 : wdata0;
                m_rd   = mem_m[m_addr];
                if (m_we) mem_m[m_addr] = m_din;
                m_pend = 1'b1;
                m_g    = cyc;
            end
        end
        cyc++;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_on) begin
            chk("ack0",     32'(ack0),     32'(m_pend && cyc == m_g + 3 && m_port == 1'b0));
            chk("ack1",     32'(ack1),     32'(m_pend && cyc == m_g + 3 && m_port == 1'b1));
            chk("busy",     32'(busy),     32'(m_pend));
            chk("ram_we",   32'(ram_we),   32'(m_pend && cyc == m_g + 1 && m_we));
            chk("ram_addr", 32'(ram_addr), 32'(m_addr));
            chk("ram_din",  32'(ram_din),  32'(m_din));
            chk("rdata0",   32'(rdata0),   32'(m_rdata[0]));
            chk("rdata1",   32'(rdata1),   32'(m_rdata[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // Wait (bounded) for the port's ack, return its cycle, then drop req.
    task automatic wait_ack(input int p, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((p == 0 && ack0) || (p == 1 && ack1)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL ack_timeout port %0d: got no ack expected ack within 40 cycles", p);
        end
        step();
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    initial begin
        int rc, a0, a1;
        int f0 [4];
        int f1 [4];
        for (int i = 0; i < 128; i++) begin
            ram_mem[i] = '0;
            mem_m[i]   = '0;
        end
        ram_dout = '0;
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values.
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);

        // Port 0 write 0xAA to 10, then read it back.
        step();
        rc = cyc;
        issue(0, 1'b1, 7'd10, 8'hAA);
        wait_ack(0, a0);
        chk("t1_write_latency", 32'(a0 - rc), 32'd3);
        step();
        issue(0, 1'b0, 7'd10, 8'h00);
        wait_ack(0, a0);
        chk("t1_read_data", 32'(rdata0), 32'hAA);

        // Simultaneous requests after reset: port 0 write first.
        rst = 1'b1;
        step();
        rst = 1'b0;
        issue(0, 1'b1, 7'd20, 8'h55);
        issue(1, 1'b0, 7'd20, 8'h00);
        fork
            wait_ack(0, a0);
            wait_ack(1, a1);
        join
        chk("t2_ack_gap", 32'(a1 - a0), 32'd4);
        chk("t2_read_data", 32'(rdata1), 32'h55);

        // Fairness: both ports re-request as soon as allowed.
        step();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    issue(0, 1'b1, 7'(40 + i), 8'(16 * i + 3));
                    wait_ack(0, f0[i]);
                    step();
                end
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    issue(1, 1'b0, 7'(40 + i), 8'h00);
                    wait_ack(1, f1[i]);
                    step();
                end
            end
        join
        for (int i = 0; i < 4; i++) begin
            chk("fair_gap_01", 32'(f1[i] - f0[i]), 32'd4);
            if (i < 3) chk("fair_gap_10", 32'(f0[i + 1] - f1[i]), 32'd4);
        end
        chk("fair_last_read", 32'(rdata1), 32'h33);

        // A write does not disturb the port's read data.
        issue(1, 1'b0, 7'd20, 8'h00);
        wait_ack(1, a1);
        chk("t4_read", 32'(rdata1), 32'h55);
        step();
        issue(1, 1'b1, 7'd5, 8'h33);
        wait_ack(1, a1);
        chk("t4_after_write", 32'(rdata1), 32'h55);

        // Address change during WAIT does not affect the read in flight.
        step();
        issue(0, 1'b0, 7'd10, 8'h00);
        step();
        step();
        addr0 = 7'd20;
        wait_ack(0, a0);
        chk("t5_stable_read", 32'(rdata0), 32'hAA);

        // Reset during WAIT of a port 1 read abandons it.
        step();
        issue(1, 1'b0, 7'd20, 8'h00);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req1 = 1'b0;
        a1 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack1) a1++;
            if (i == 0) begin
                chk("t6_busy", 32'(busy), 32'd0);
                chk("t6_rdata1", 32'(rdata1), 32'd0);
            end
        end
        chk("t6_no_ack1", 32'(a1), 32'd0);
        step();
        issue(0, 1'b0, 7'd10, 8'h00);
        issue(1, 1'b0, 7'd5, 8'h00);
        fork
            wait_ack(0, a0);
            wait_ack(1, a1);
        join
        chk("t6_prio_port0_first", 32'(a1 - a0), 32'd4);
        chk("t6_rdata0", 32'(rdata0), 32'hAA);
        chk("t6_rdata1", 32'(rdata1), 32'h33);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
